// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: captures a WIDTH-bit word and emits it one bit per cycle, MSB or LSB first.
// Latency: first bit on the cycle after accept, done with the last bit WIDTH cycles after accept.
// Backpressure: ready is low while a word is in flight; load is ignored until ready returns high.
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             msb_first,
    output logic             ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LAST  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               msb_q, msb_d;
    logic               x_out_q, x_out_d;
    logic               x_valid_q, x_valid_d;
    logic               done_q, done_d;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        msb_d     = msb_q;
        x_out_d   = 1'b0;
        x_valid_d = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d   = data_in;
                    msb_d     = msb_first;
                    cnt_d     = '0;
                    x_out_d   = msb_first ? data_in[WIDTH-1] : data_in[0];
                    x_valid_d = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // The bit on x_out is always at the exit end of shreg; shift it out and expose its neighbour.
                shreg_d   = msb_q ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
                x_out_d   = msb_q ? shreg_q[WIDTH-2] : shreg_q[1];
                x_valid_d = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == PENULT_IDX) begin
                    state_d = LAST;
                    done_d  = 1'b1;
                end
            end
            LAST: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            msb_q     <= 1'b0;
            x_out_q   <= 1'b0;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            msb_q     <= msb_d;
            x_out_q   <= x_out_d;
            x_valid_q <= x_valid_d;
            done_q    <= done_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign x_out   = x_out_q;
    assign x_valid = x_valid_q;
    assign done    = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: word-level reference model checked every cycle, plus directed literal scenarios.
module tb_bit_serializer;

    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             msb_first;
    logic             ready;
    logic             x_out;
    logic             x_valid;
    logic             done;

    int checks = 0;
    int errors = 0;

    bit_serializer #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .data_in  (data_in),
        .msb_first(msb_first),
        .ready    (ready),
        .x_out    (x_out),
        .x_valid  (x_valid),
        .done     (done)
    );

    always #5 clock = ~clock;

    // Reference: a word in flight is described by its value, order and cycles elapsed since accept.
    bit               m_armed = 1'b0;
    bit               m_busy  = 1'b0;
    int               m_pos   = 0;
    logic [WIDTH-1:0] m_word  = '0;
    logic             m_msb   = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_armed = 1'b1;
            m_busy  = 1'b0;
            m_pos   = 0;
        end else if (m_busy) begin
            if (m_pos == WIDTH) m_busy = 1'b0;
            else                m_pos  = m_pos + 1;
        end else if (load) begin
            m_busy = 1'b1;
            m_pos  = 1;
            m_word = data_in;
            m_msb  = msb_first;
        end
    end

    always @(negedge clock) begin
        logic [3:0] exp_v;
        logic [3:0] act_v;
        logic       exp_bit;
        if (m_armed) begin
            exp_bit = 1'b0;
            if (m_busy) exp_bit = m_word[m_msb ? (WIDTH - m_pos) : (m_pos - 1)];
            exp_v = {!m_busy, m_busy, exp_bit, (m_busy && m_pos == WIDTH)};
            act_v = {ready, x_valid, x_out, done};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_model t=%0t {ready,x_valid,x_out,done} got %b expected %b",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Accept one word, then collect WIDTH cycles of output; optionally disturb inputs mid-word.
    task automatic send_word(input logic [WIDTH-1:0] w, input logic msb, input bit disturb,
                             output logic [WIDTH-1:0] seq, output int vcnt,
                             output int dcnt, output int dpos);
        load = 1'b1; data_in = w; msb_first = msb;
        step();
        load = 1'b0;
        seq = '0; vcnt = 0; dcnt = 0; dpos = -1;
        for (int i = 0; i < WIDTH; i++) begin
            seq = {seq[WIDTH-2:0], x_out};
            if (x_valid) vcnt++;
            if (done) begin dcnt++; dpos = i; end
            if (disturb) begin
                data_in   = WIDTH'($urandom);
                msb_first = ~msb_first;
                load      = (i < WIDTH - 1);
            end
            step();
        end
        load = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] seq;
        logic [15:0]      bits;
        int vcnt, dcnt, dpos, nb, acc0, acc1, nacc;

        reset = 1'b1; load = 1'b0; data_in = '0; msb_first = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_lit("reset_ready", int'(ready), 1);
        check_lit("reset_x_valid", int'(x_valid), 0);
        check_lit("reset_done", int'(done), 0);

        send_word(8'hB4, 1'b1, 1'b0, seq, vcnt, dcnt, dpos);
        check_lit("b4_msb_stream", int'(seq), 'hB4);
        check_lit("b4_msb_valid_cnt", vcnt, 8);
        check_lit("b4_msb_done_cnt", dcnt, 1);
        check_lit("b4_msb_done_pos", dpos, 7);
        check_lit("b4_msb_ready_after", int'(ready), 1);

        send_word(8'hB4, 1'b0, 1'b1, seq, vcnt, dcnt, dpos);
        check_lit("b4_lsb_stream", int'(seq), 'h2D);
        check_lit("b4_lsb_done_pos", dpos, 7);

        // Continuous load: accepts must be WIDTH+1 cycles apart with an unbroken bit stream.
        load = 1'b1; data_in = 8'h0F; msb_first = 1'b1;
        bits = '0; nb = 0; nacc = 0; acc0 = -1; acc1 = -1;
        for (int j = 0; j < 20; j++) begin
            if (ready) begin
                if (nacc == 0) acc0 = j;
                else if (nacc == 1) acc1 = j;
                nacc++;
            end
            if (x_valid && nb < 16) begin bits = {bits[14:0], x_out}; nb++; end
            if (j == 1) data_in = 8'hF0;
            step();
        end
        load = 1'b0;
        check_lit("spacing", acc1 - acc0, 9);
        check_lit("back2back_stream", int'(bits), 'h0FF0);
        check_lit("back2back_bits", nb, 16);
        for (int j = 0; j < 10; j++) step();

        // Reset while the fourth bit is on the line.
        load = 1'b1; data_in = 8'hFF; msb_first = 1'b1;
        step();
        load = 1'b0;
        for (int j = 0; j < 3; j++) step();
        check_lit("abort_pre_valid", int'(x_valid), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_lit("abort_x_valid", int'(x_valid), 0);
        check_lit("abort_x_out", int'(x_out), 0);
        check_lit("abort_ready", int'(ready), 1);
        dcnt = 0;
        for (int j = 0; j < 12; j++) begin
            if (done) dcnt++;
            step();
        end
        check_lit("abort_no_done", dcnt, 0);

        reset = 1'b1; load = 1'b1; data_in = 8'h5A;
        step();
        reset = 1'b0; load = 1'b0;
        vcnt = 0;
        for (int j = 0; j < 10; j++) begin
            if (x_valid) vcnt++;
            step();
        end
        check_lit("reset_load_no_accept", vcnt, 0);

        send_word(8'hAA, 1'b1, 1'b0, seq, vcnt, dcnt, dpos);
        check_lit("aa_stream", int'(seq), 'hAA);

        for (int n = 0; n < 3000; n++) begin
            load      = ($urandom_range(0, 3) != 0);
            data_in   = WIDTH'($urandom);
            msb_first = 1'($urandom);
            reset     = ($urandom_range(0, 79) == 0);
            step();
        end
        reset = 1'b0; load = 1'b0;
        for (int j = 0; j < 12; j++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
